// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor miss statistics block.
//   ID_W        : branch ID width, matches the predictor's branchID
//   rd_state_e  : read-port FSM states
//   sat_inc     : saturating increment for any counter width up to 64 bits
package bp_pkg;

  localparam int unsigned ID_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone
  } rd_state_e;

  // Increment value, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Width-parameterised saturating event counter.
//   clk   : clock
//   reset : synchronous, active-high; zeroes the count
//   clear : synchronous clear, lower priority than reset, higher than inc
//   inc   : add one this edge, holding at all-ones
//   count : registered count
module bp_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  import bp_pkg::*;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = W'(sat_inc(64'(count_q), W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bp_miss_stats.sv
// Miss statistics monitor for the 1-bit branch history predictor.
// Pairs each branch event with the predictor's registered miss one cycle
// later, keeps per-ID and global branch/miss counts, raises a sticky alarm
// when a fixed event window holds too many misses, and serves per-ID counts
// through a req/ack read port.
//   clk, reset               : clock, synchronous active-high reset
//   br_valid, br_id          : branch event presented to the predictor
//   miss                     : predictor miss, valid one cycle after br_valid
//   clear                    : synchronous clear of counters, window and alarm
//   rd_req, rd_id            : read request (accepted only when idle)
//   rd_ack                   : one-cycle pulse, rd_total/rd_misses valid
//   rd_total, rd_misses      : per-ID counts for the accepted rd_id
//   total_branches/misses    : global counts
//   alarm                    : sticky window miss-rate alarm
module bp_miss_stats #(
  parameter int unsigned NUM_IDS      = 8,
  parameter int unsigned ID_W         = bp_pkg::ID_W,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned GCNT_W       = 24,
  parameter int unsigned WIN          = 64,
  parameter int unsigned ALARM_THRESH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [ID_W-1:0]   br_id,
  input  logic              miss,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ID_W-1:0]   rd_id,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  rd_total,
  output logic [CNT_W-1:0]  rd_misses,
  output logic [GCNT_W-1:0] total_branches,
  output logic [GCNT_W-1:0] total_misses,
  output logic              alarm
);
  import bp_pkg::*;

  // win_miss may reach WIN, so one bit wider than log2(WIN).
  localparam int unsigned WinW = $clog2(WIN) + 1;

  // Alignment stage: miss arriving now belongs to the event registered here.
  logic            s1_valid_q;
  logic [ID_W-1:0] s1_id_q;
  logic            commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
    end else begin
      s1_valid_q <= br_valid;
      s1_id_q    <= br_id;
    end
  end

  // Out-of-range IDs are dropped from every count, including the window.
  assign commit = s1_valid_q && (32'(s1_id_q) < NUM_IDS);

  // Per-ID counters.
  logic [CNT_W-1:0] tot_cnt [NUM_IDS];
  logic [CNT_W-1:0] mis_cnt [NUM_IDS];

  for (genvar i = 0; i < NUM_IDS; i++) begin : g_id
    logic hit;
    assign hit = commit && (32'(s1_id_q) == i);

    bp_sat_counter #(.W(CNT_W)) u_tot (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .inc  (hit),
      .count(tot_cnt[i])
    );

    bp_sat_counter #(.W(CNT_W)) u_mis (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .inc  (hit && miss),
      .count(mis_cnt[i])
    );
  end

  // Global counters keep running even when a per-ID counter has saturated.
  bp_sat_counter #(.W(GCNT_W)) u_gtot (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (commit),
    .count(total_branches)
  );

  bp_sat_counter #(.W(GCNT_W)) u_gmis (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (commit && miss),
    .count(total_misses)
  );

  // Window miss-rate alarm.
  logic [WinW-1:0] win_cnt_q, win_cnt_d, win_cnt_inc;
  logic [WinW-1:0] win_miss_q, win_miss_d, win_miss_inc;
  logic            alarm_q, alarm_d;

  always_comb begin
    win_cnt_d    = win_cnt_q;
    win_miss_d   = win_miss_q;
    alarm_d      = alarm_q;
    win_cnt_inc  = win_cnt_q + WinW'(1);
    win_miss_inc = win_miss_q;
    if (miss && (32'(win_miss_q) < WIN)) begin
      win_miss_inc = win_miss_q + WinW'(1);
    end

    if (clear) begin
      win_cnt_d  = '0;
      win_miss_d = '0;
      alarm_d    = 1'b0;
    end else if (commit) begin
      if (32'(win_cnt_inc) == WIN) begin
        // The closing event's own miss counts toward this window.
        if (32'(win_miss_inc) >= ALARM_THRESH) begin
          alarm_d = 1'b1;
        end
        win_cnt_d  = '0;
        win_miss_d = '0;
      end else begin
        win_cnt_d  = win_cnt_inc;
        win_miss_d = win_miss_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      win_miss_q <= '0;
      alarm_q    <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_miss_q <= win_miss_d;
      alarm_q    <= alarm_d;
    end
  end

  assign alarm = alarm_q;

  // Read port FSM. FETCH samples the counters as they stand before the edge,
  // so a commit or clear on that same edge is not reflected in the result.
  rd_state_e        state_q, state_d;
  logic [ID_W-1:0]  rd_id_q, rd_id_d;
  logic [CNT_W-1:0] rd_total_q, rd_total_d;
  logic [CNT_W-1:0] rd_misses_q, rd_misses_d;
  logic             rd_ack_q, rd_ack_d;

  always_comb begin
    state_d     = state_q;
    rd_id_d     = rd_id_q;
    rd_total_d  = rd_total_q;
    rd_misses_d = rd_misses_q;
    rd_ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          rd_id_d = rd_id;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (32'(rd_id_q) < NUM_IDS) begin
          rd_total_d  = tot_cnt[rd_id_q];
          rd_misses_d = mis_cnt[rd_id_q];
        end else begin
          rd_total_d  = '0;
          rd_misses_d = '0;
        end
        rd_ack_d = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_id_q     <= '0;
      rd_total_q  <= '0;
      rd_misses_q <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_id_q     <= rd_id_d;
      rd_total_q  <= rd_total_d;
      rd_misses_q <= rd_misses_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_total  = rd_total_q;
  assign rd_misses = rd_misses_q;

endmodule
